reg_file_checker: RTL and testbench

REG_FILE_CHECKER -- requirements
Module: reg_file_checker

---
 rtl/reg_file_checker_pkg.sv | 21 ++
 rtl/reg_file_checker_store.sv | 54 +++++
 rtl/reg_file_checker.sv | 196 +++++++++++++++++++
 tb/tb_reg_file_checker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file_checker_pkg                                          |
// | Brief    : Shared state encoding for the register-file checker.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package reg_file_checker_pkg;

    localparam int c_state_w = 3;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_SEL  = 3'd2,
        ST_CMP  = 3'd3,
        ST_DUMP = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage : reg_file_checker_pkg
`default_nettype wire

// File: rtl/reg_file_checker_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file_checker_store                                        |
// | Brief    : Expected-value and compare-mask storage, one write port and   |
// |            one combinational read port.                                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reg_file_checker_store
    import reg_file_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int SEL_BITS   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [SEL_BITS-1:0]   i_wr_index,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [DATA_WIDTH-1:0] i_wr_mask,
    input  logic [SEL_BITS-1:0]   i_rd_index,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [DATA_WIDTH-1:0] o_rd_mask
);

    logic [DATA_WIDTH-1:0] w_exp_arr  [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_mask_arr [NUM_REGS];

    // Indices with no matching entry decode to nothing, so out-of-range writes drop.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        localparam logic [SEL_BITS-1:0] c_idx = SEL_BITS'(g);

        logic [DATA_WIDTH-1:0] r_expected;
        logic [DATA_WIDTH-1:0] r_mask;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_expected <= '0;
                r_mask     <= '1;
            end else if (i_wr_en && (i_wr_index == c_idx)) begin
                r_expected <= i_wr_data;
                r_mask     <= i_wr_mask;
            end
        end

        assign w_exp_arr[g]  = r_expected;
        assign w_mask_arr[g] = r_mask;
    end

    assign o_rd_data = w_exp_arr[i_rd_index];
    assign o_rd_mask = w_mask_arr[i_rd_index];

endmodule : reg_file_checker_store
`default_nettype wire

// File: rtl/reg_file_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file_checker                                              |
// | Brief    : Waits a programmable delay, then scans a register file and    |
// |            compares every entry against masked expected values.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reg_file_checker
    import reg_file_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int SEL_BITS   = 5,
    parameter int WAIT_BITS  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WAIT_BITS-1:0]  test_length,
    input  logic                  exp_write,
    input  logic [SEL_BITS-1:0]   exp_index,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [DATA_WIDTH-1:0] exp_mask,
    output logic [SEL_BITS-1:0]   rf_read_sel,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  test_passed,
    output logic [SEL_BITS:0]     mismatch_count,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [SEL_BITS-1:0]   dump_index,
    output logic [DATA_WIDTH-1:0] dump_expected,
    output logic [DATA_WIDTH-1:0] dump_actual
);

    localparam logic [SEL_BITS-1:0] c_last_index = SEL_BITS'(NUM_REGS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [WAIT_BITS-1:0]  r_wait_cnt;
    logic [SEL_BITS-1:0]   r_index;
    logic [SEL_BITS-1:0]   r_rf_read_sel;
    logic [SEL_BITS:0]     r_mismatch_count;
    logic                  r_test_passed;
    logic [SEL_BITS-1:0]   r_dump_index;
    logic [DATA_WIDTH-1:0] r_dump_expected;
    logic [DATA_WIDTH-1:0] r_dump_actual;

    logic [DATA_WIDTH-1:0] w_exp_data;
    logic [DATA_WIDTH-1:0] w_exp_mask;
    logic                  w_store_wr;
    logic                  w_mismatch;
    logic                  w_last;
    logic                  w_advance;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_dump_valid;

    // Expected values are only writable while no test is in flight.
    assign w_store_wr = exp_write && (r_state == ST_IDLE);

    reg_file_checker_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .SEL_BITS   (SEL_BITS)
    ) u_store (
        .clock      (clock),
        .reset      (reset),
        .i_wr_en    (w_store_wr),
        .i_wr_index (exp_index),
        .i_wr_data  (exp_data),
        .i_wr_mask  (exp_mask),
        .i_rd_index (r_index),
        .o_rd_data  (w_exp_data),
        .o_rd_mask  (w_exp_mask)
    );

    assign w_mismatch = |((w_exp_data ^ rf_read_data) & w_exp_mask);
    assign w_last     = (r_index == c_last_index);
    assign w_advance  = ((r_state == ST_CMP) && !w_mismatch) ||
                        ((r_state == ST_DUMP) && dump_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_dump_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = ST_SEL;
                end
            end
            ST_SEL: begin
                w_state_next = ST_CMP;
            end
            ST_CMP: begin
                if (w_mismatch) begin
                    w_state_next = ST_DUMP;
                end else begin
                    w_state_next = w_last ? ST_DONE : ST_SEL;
                end
            end
            ST_DUMP: begin
                w_dump_valid = 1'b1;
                if (dump_ready) begin
                    w_state_next = w_last ? ST_DONE : ST_SEL;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt       <= '0;
            r_index          <= '0;
            r_rf_read_sel    <= '0;
            r_mismatch_count <= '0;
            r_test_passed    <= 1'b0;
            r_dump_index     <= '0;
            r_dump_expected  <= '0;
            r_dump_actual    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_wait_cnt       <= test_length;
                        r_mismatch_count <= '0;
                        r_test_passed    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else begin
                        r_index       <= '0;
                        r_rf_read_sel <= '0;
                    end
                end
                ST_CMP: begin
                    if (w_mismatch) begin
                        r_mismatch_count <= r_mismatch_count + 1'b1;
                        r_dump_index     <= r_index;
                        r_dump_expected  <= w_exp_data;
                        r_dump_actual    <= rf_read_data;
                    end
                end
                ST_DONE: begin
                    r_test_passed <= (r_mismatch_count == '0);
                end
                default: begin
                end
            endcase

            // The read select moves only when the next SEL begins, so it holds elsewhere.
            if (w_advance && !w_last) begin
                r_index       <= r_index + 1'b1;
                r_rf_read_sel <= r_index + 1'b1;
            end
        end
    end

    assign rf_read_sel    = r_rf_read_sel;
    assign busy           = w_busy;
    assign done           = w_done;
    assign dump_valid     = w_dump_valid;
    assign test_passed    = r_test_passed;
    assign mismatch_count = r_mismatch_count;
    assign dump_index     = r_dump_index;
    assign dump_expected  = r_dump_expected;
    assign dump_actual    = r_dump_actual;

endmodule : reg_file_checker
`default_nettype wire

// File: tb/tb_reg_file_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_file_checker                                           |
// | Brief    : Scoreboard bench for reg_file_checker with a register-file    |
// |            model and randomized expected/actual contents.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_reg_file_checker;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int SB = 5;
    localparam int WB = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [WB-1:0] test_length;
    logic          exp_write;
    logic [SB-1:0] exp_index;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_mask;
    logic [SB-1:0] rf_read_sel;
    logic [DW-1:0] rf_read_data;
    logic          busy;
    logic          done;
    logic          test_passed;
    logic [SB:0]   mismatch_count;
    logic          dump_valid;
    logic          dump_ready;
    logic [SB-1:0] dump_index;
    logic [DW-1:0] dump_expected;
    logic [DW-1:0] dump_actual;

    reg_file_checker #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .SEL_BITS   (SB),
        .WAIT_BITS  (WB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .test_length    (test_length),
        .exp_write      (exp_write),
        .exp_index      (exp_index),
        .exp_data       (exp_data),
        .exp_mask       (exp_mask),
        .rf_read_sel    (rf_read_sel),
        .rf_read_data   (rf_read_data),
        .busy           (busy),
        .done           (done),
        .test_passed    (test_passed),
        .mismatch_count (mismatch_count),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_index     (dump_index),
        .dump_expected  (dump_expected),
        .dump_actual    (dump_actual)
    );

    typedef struct {
        bit          is_done;
        int          idx;
        logic [DW-1:0] expv;
        logic [DW-1:0] act;
        int          cnt;
        bit          passed;
        int          lat;
    } item_t;

    item_t         sb_q[$];
    logic [DW-1:0] exp_m  [NR];
    logic [DW-1:0] mask_m [NR];
    logic [DW-1:0] rf_m   [NR];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int stall_cfg = 0;
    int stall_cnt = 0;
    bit in_dump = 0;
    bit tp_pending = 0;
    bit tp_exp = 0;
    logic [SB-1:0] held_idx;
    logic [DW-1:0] held_exp;
    logic [DW-1:0] held_act;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // Register file under test: one-cycle read latency.
    always @(posedge clock) rf_read_data <= rf_m[rf_read_sel];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},        busy, 0);
        check({tag, "_done"},        done, 0);
        check({tag, "_test_passed"}, test_passed, 0);
        check({tag, "_mismatch"},    mismatch_count, 0);
        check({tag, "_dump_valid"},  dump_valid, 0);
        check({tag, "_rf_read_sel"}, rf_read_sel, 0);
        check({tag, "_dump_index"},  dump_index, 0);
        check({tag, "_dump_exp"},    dump_expected, 0);
        check({tag, "_dump_act"},    dump_actual, 0);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            exp_m[i]  = '0;
            mask_m[i] = '1;
        end
    endfunction

    // Expected outcome of one scan: a dump per masked difference, then done.
    function automatic void push_expect(input int tl);
        item_t it;
        int nd = 0;
        for (int i = 0; i < NR; i++) begin
            if (((exp_m[i] ^ rf_m[i]) & mask_m[i]) != '0) begin
                nd++;
                it.is_done = 0; it.idx = i; it.expv = exp_m[i]; it.act = rf_m[i];
                it.cnt = nd; it.passed = 0; it.lat = 0;
                sb_q.push_back(it);
            end
        end
        it.is_done = 1; it.idx = 0; it.expv = '0; it.act = '0;
        it.cnt = nd; it.passed = (nd == 0);
        it.lat = 1 + (tl + 1) + 2 * NR + nd * (1 + stall_cfg);
        sb_q.push_back(it);
    endfunction

    task automatic write_exp(input int idx, input logic [DW-1:0] d, input logic [DW-1:0] m);
        @(negedge clock);
        exp_write = 1'b1; exp_index = SB'(idx); exp_data = d; exp_mask = m;
        @(negedge clock);
        exp_write = 1'b0;
        exp_m[idx] = d; mask_m[idx] = m;
    endtask

    task automatic start_test(input int tl);
        push_expect(tl);
        @(negedge clock);
        test_length = WB'(tl); start = 1'b1; t0 = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_test(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_completed"}, sb_q.size() == 0, 1);
        sb_q.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_sel(input int idx, input string name);
        int n = 0;
        while (rf_read_sel != SB'(idx) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_reached_sel"}, rf_read_sel, idx);
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clock);
            if (reset) begin
                dump_ready = 1'b0; stall_cnt = 0; in_dump = 0; tp_pending = 0;
            end else begin
                if (tp_pending) begin
                    check("test_passed", test_passed, tp_exp);
                    tp_pending = 0;
                end
                if (dump_valid) begin
                    if (in_dump) begin
                        check("dump_index_stable", dump_index, held_idx);
                        check("dump_expected_stable", dump_expected, held_exp);
                        check("dump_actual_stable", dump_actual, held_act);
                    end else begin
                        held_idx = dump_index; held_exp = dump_expected; held_act = dump_actual;
                        in_dump = 1;
                    end
                    if (stall_cnt >= stall_cfg) begin
                        dump_ready = 1'b1; stall_cnt = 0;
                    end else begin
                        dump_ready = 1'b0; stall_cnt++;
                    end
                    if (dump_ready) begin
                        in_dump = 0;
                        check("dump_was_expected", (sb_q.size() != 0) && !sb_q[0].is_done, 1);
                        if (sb_q.size() != 0 && !sb_q[0].is_done) begin
                            it = sb_q.pop_front();
                            check("dump_index", dump_index, it.idx);
                            check("dump_expected", dump_expected, it.expv);
                            check("dump_actual", dump_actual, it.act);
                            check("dump_mismatch_count", mismatch_count, it.cnt);
                        end
                    end
                end else begin
                    dump_ready = 1'b0;
                end
                if (done) begin
                    check("done_was_expected", (sb_q.size() != 0) && sb_q[0].is_done, 1);
                    if (sb_q.size() != 0 && sb_q[0].is_done) begin
                        it = sb_q.pop_front();
                        check("done_mismatch_count", mismatch_count, it.cnt);
                        check("done_latency", cyc - t0 + 1, it.lat);
                        tp_pending = 1; tp_exp = it.passed;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int seen;
        reset = 1'b1; start = 1'b0; test_length = '0; exp_write = 1'b0;
        exp_index = '0; exp_data = '0; exp_mask = '0; dump_ready = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) rf_m[i] = '0;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("after_reset");

        // Clean pass with ABI-style register values.
        write_exp(11, 32'h13, '1); rf_m[11] = 32'h13;
        for (int k = 0; k < 6; k++) begin
            write_exp(12 + k, 32'hffff8000 + k, '1);
            rf_m[12 + k] = 32'hffff8000 + k;
        end
        stall_cfg = 0;
        start_test(100);
        @(negedge clock);
        check("busy_in_test", busy, 1);
        wait_test("clean");
        check("sel_holds_last", rf_read_sel, NR - 1);
        check("idle_not_busy", busy, 0);

        // Single mismatch on reg 13.
        rf_m[13] = 32'hffff8011;
        start_test(5);
        wait_test("one_mismatch");

        // Same difference hidden by the mask.
        write_exp(13, 32'hffff8001, 32'hffffff0f);
        start_test(5);
        wait_test("masked");
        write_exp(13, 32'hffff8001, '1);
        rf_m[13] = 32'hffff8001;

        // Three mismatches with a stalled consumer.
        rf_m[0] = 32'h1; rf_m[15] = 32'h5a; rf_m[31] = 32'h80000000;
        stall_cfg = 5;
        start_test(3);
        wait_test("stalled_dumps");
        rf_m[0] = '0; rf_m[15] = '0; rf_m[31] = '0;
        stall_cfg = 0;

        // Restart during WAIT and a write during SEL must both be ignored.
        start_test(10);
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_sel(5, "busy_write");
        exp_write = 1'b1; exp_index = SB'(20); exp_data = 32'hdeadbeef; exp_mask = '1;
        @(negedge clock);
        exp_write = 1'b0;
        wait_test("busy_ignore");

        // Randomized contents, masks, delays and consumer stalls.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NR; i++) begin
                logic [DW-1:0] d;
                logic [DW-1:0] m;
                d = $urandom;
                m = ($urandom_range(0, 1) == 0) ? '1 : ($urandom | $urandom);
                write_exp(i, d, m);
                rf_m[i] = d;
                if ($urandom_range(0, 7) == 0) rf_m[i] = d ^ (32'h1 << $urandom_range(0, 31));
            end
            stall_cfg = $urandom_range(0, 3);
            start_test($urandom_range(0, 20));
            wait_test("random");
        end
        stall_cfg = 0;
        for (int i = 0; i < NR; i++) rf_m[i] = exp_m[i];

        // Reset during CMP of reg 10 abandons the test silently.
        start_test(4);
        wait_sel(10, "mid_reset");
        @(negedge clock);
        reset = 1'b1;
        sb_q.delete();
        #1;
        check_reset_vals("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) seen++;
        end
        check("no_done_after_reset", seen, 0);
        check("idle_after_reset", busy, 0);

        // Store was cleared by reset; zero register file with zero delay passes.
        for (int i = 0; i < NR; i++) rf_m[i] = '0;
        start_test(0);
        wait_test("post_reset_clean");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_file_checker
`default_nettype wire
